// File: rtl/vred_issue_if.sv
// Request / VRF read / reducer-stream bundle for the vector reduction issue sequencer.
// The slave modport is the sequencer side; master is the requester/VRF/reducer environment.
interface vred_issue_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int OPSEL_WIDTH = 5,
    parameter int SEW_WIDTH   = 2,
    parameter int VL_WIDTH    = 12
);
    logic                   req_valid;
    logic                   req_ready;
    logic [VL_WIDTH-1:0]    req_vl;
    logic [SEW_WIDTH-1:0]   req_sew;
    logic [OPSEL_WIDTH-1:0] req_opsel;
    logic [ADDR_WIDTH-1:0]  req_vs1_addr;
    logic [ADDR_WIDTH-1:0]  req_vs2_addr;
    logic [ADDR_WIDTH-1:0]  req_vd_addr;
    logic                   rd_en;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [DATA_WIDTH-1:0]  red_vec0;
    logic [DATA_WIDTH-1:0]  red_vec1;
    logic                   red_valid;
    logic                   red_start;
    logic                   red_end;
    logic [OPSEL_WIDTH-1:0] red_opsel;
    logic [SEW_WIDTH-1:0]   red_sew;
    logic [ADDR_WIDTH-1:0]  red_addr;
    logic                   done;
    logic                   err;

    modport slave (
        input  req_valid, req_vl, req_sew, req_opsel, req_vs1_addr, req_vs2_addr, req_vd_addr, rd_data,
        output req_ready, rd_en, rd_addr, red_vec0, red_vec1, red_valid, red_start, red_end,
               red_opsel, red_sew, red_addr, done, err
    );

    modport master (
        output req_valid, req_vl, req_sew, req_opsel, req_vs1_addr, req_vs2_addr, req_vd_addr, rd_data,
        input  req_ready, rd_en, rd_addr, red_vec0, red_vec1, red_valid, red_start, red_end,
               red_opsel, red_sew, red_addr, done, err
    );
endinterface

// File: rtl/vred_issue_seq.sv
// Issue sequencer for the vector reduction pipeline: reads vs1 then vs2 beats from the VRF and streams them.
// Optional macro VRED_ISSUE_TAIL_FILL_EN: replace elements past vl on the last beat with the op identity.
module vred_issue_seq #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 32,
    parameter int OPSEL_WIDTH   = 5,
    parameter int SEW_WIDTH     = 2,
    parameter int VL_WIDTH      = 12,
    parameter bit ENABLE_64_BIT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    vred_issue_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD_VS1, RD_VS2, DRAIN} state_t;

    state_t                 state_reg;
    logic [VL_WIDTH-1:0]    cnt_reg;
    logic [VL_WIDTH-1:0]    nbeats_reg;
    logic [ADDR_WIDTH-1:0]  vs2_addr_reg;
    logic                   req_ready_reg, rd_en_reg, done_reg, err_reg;
    logic [ADDR_WIDTH-1:0]  rd_addr_reg;
    // p1_* describe the read issued this cycle, p2_* the read whose data is on rd_data now
    logic                   p1_vs1_reg, p1_vs2_reg, p1_start_reg, p1_end_reg;
    logic                   p2_vs1_reg, p2_vs2_reg, p2_start_reg, p2_end_reg;
    logic [DATA_WIDTH-1:0]  red_vec0_reg, red_vec1_reg;
    logic                   red_valid_reg, red_start_reg, red_end_reg;
    logic [OPSEL_WIDTH-1:0] red_opsel_reg;
    logic [SEW_WIDTH-1:0]   red_sew_reg;
    logic [ADDR_WIDTH-1:0]  red_addr_reg;

    logic [2:0]             epb_m1;
    logic [VL_WIDTH:0]      vl_sum;
    logic [VL_WIDTH-1:0]    nbeats_calc;
    logic [DATA_WIDTH-1:0]  fill_vec;
    logic                   reject;

    assign epb_m1      = 3'd7 >> bus.req_sew;
    assign vl_sum      = {1'b0, bus.req_vl} + {{(VL_WIDTH-2){1'b0}}, epb_m1};
    assign nbeats_calc = VL_WIDTH'(vl_sum >> (2'd3 - bus.req_sew));
    assign reject      = !ENABLE_64_BIT && (bus.req_sew == 2'd3);

`ifdef VRED_ISSUE_TAIL_FILL_EN
    logic [2:0] live_reg;
    logic [2:0] byte_mask;
    logic       tail_fill;

    assign byte_mask = 3'((4'd1 << red_sew_reg) - 4'd1);
    assign tail_fill = p2_end_reg && (live_reg != 3'd0);

    // Byte gi belongs to lane gi>>sew; the lane's top byte carries the sign bit of min/max identities.
    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_fill
        localparam logic [2:0] BI = 3'(gi);
        logic       is_top;
        logic       fill_en;
        logic [7:0] id_byte;
        assign is_top  = (BI & byte_mask) == byte_mask;
        assign fill_en = tail_fill && ((BI >> red_sew_reg) >= live_reg);
        assign id_byte = (red_opsel_reg == 5'd1 || red_opsel_reg == 5'd4) ? 8'hFF :
                         (red_opsel_reg == 5'd5) ? (is_top ? 8'h7F : 8'hFF) :
                         (red_opsel_reg == 5'd7) ? (is_top ? 8'h80 : 8'h00) : 8'h00;
        assign fill_vec[gi*8 +: 8] = fill_en ? id_byte : bus.rd_data[gi*8 +: 8];
    end
`else
    assign fill_vec = bus.rd_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            nbeats_reg    <= '0;
            vs2_addr_reg  <= '0;
            req_ready_reg <= 1'b1;
            rd_en_reg     <= 1'b0;
            rd_addr_reg   <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            p1_vs1_reg    <= 1'b0;
            p1_vs2_reg    <= 1'b0;
            p1_start_reg  <= 1'b0;
            p1_end_reg    <= 1'b0;
            p2_vs1_reg    <= 1'b0;
            p2_vs2_reg    <= 1'b0;
            p2_start_reg  <= 1'b0;
            p2_end_reg    <= 1'b0;
            red_vec0_reg  <= '0;
            red_vec1_reg  <= '0;
            red_valid_reg <= 1'b0;
            red_start_reg <= 1'b0;
            red_end_reg   <= 1'b0;
            red_opsel_reg <= '0;
            red_sew_reg   <= '0;
            red_addr_reg  <= '0;
`ifdef VRED_ISSUE_TAIL_FILL_EN
            live_reg      <= '0;
`endif
        end else begin
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            p2_vs1_reg    <= p1_vs1_reg;
            p2_vs2_reg    <= p1_vs2_reg;
            p2_start_reg  <= p1_start_reg;
            p2_end_reg    <= p1_end_reg;
            red_valid_reg <= p2_vs2_reg;
            red_vec0_reg  <= p2_vs2_reg ? fill_vec : '0;
            red_start_reg <= p2_vs2_reg && p2_start_reg;
            red_end_reg   <= p2_vs2_reg && p2_end_reg;
            if (p2_vs1_reg) red_vec1_reg <= bus.rd_data;

            case (state_reg)
                IDLE: begin
                    if (bus.req_valid && req_ready_reg) begin
                        red_opsel_reg <= bus.req_opsel;
                        red_sew_reg   <= bus.req_sew;
                        red_addr_reg  <= bus.req_vd_addr;
                        vs2_addr_reg  <= bus.req_vs2_addr;
                        nbeats_reg    <= nbeats_calc;
`ifdef VRED_ISSUE_TAIL_FILL_EN
                        live_reg      <= bus.req_vl[2:0] & epb_m1;
`endif
                        if (reject) begin
                            err_reg <= 1'b1;
                        end else if (bus.req_vl == '0) begin
                            state_reg     <= DRAIN;
                            done_reg      <= 1'b1;
                            req_ready_reg <= 1'b0;
                        end else begin
                            state_reg     <= RD_VS1;
                            req_ready_reg <= 1'b0;
                            rd_en_reg     <= 1'b1;
                            rd_addr_reg   <= bus.req_vs1_addr;
                            p1_vs1_reg    <= 1'b1;
                        end
                    end
                end
                RD_VS1: begin
                    p1_vs1_reg   <= 1'b0;
                    p1_vs2_reg   <= 1'b1;
                    p1_start_reg <= 1'b1;
                    p1_end_reg   <= (nbeats_reg == VL_WIDTH'(1));
                    rd_addr_reg  <= vs2_addr_reg;
                    cnt_reg      <= VL_WIDTH'(1);
                    state_reg    <= RD_VS2;
                end
                RD_VS2: begin
                    p1_start_reg <= 1'b0;
                    // cnt_reg is the index of the next beat to read
                    if (cnt_reg == nbeats_reg) begin
                        rd_en_reg  <= 1'b0;
                        p1_vs2_reg <= 1'b0;
                        p1_end_reg <= 1'b0;
                        state_reg  <= DRAIN;
                    end else begin
                        rd_addr_reg <= vs2_addr_reg + ADDR_WIDTH'(cnt_reg);
                        p1_end_reg  <= (cnt_reg == nbeats_reg - VL_WIDTH'(1));
                        cnt_reg     <= cnt_reg + VL_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (done_reg) begin
                        state_reg     <= IDLE;
                        req_ready_reg <= 1'b1;
                    end else if (p2_vs2_reg && p2_end_reg) begin
                        done_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rd_en     = rd_en_reg;
    assign bus.rd_addr   = rd_addr_reg;
    assign bus.red_vec0  = red_vec0_reg;
    assign bus.red_vec1  = red_vec1_reg;
    assign bus.red_valid = red_valid_reg;
    assign bus.red_start = red_start_reg;
    assign bus.red_end   = red_end_reg;
    assign bus.red_opsel = red_opsel_reg;
    assign bus.red_sew   = red_sew_reg;
    assign bus.red_addr  = red_addr_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
endmodule
